// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        NONE,
        TRAP,
        BRANCH,
        RET,
        SEQ
    } redirect_e;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_INSTR_BYTES  = 4;
    localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control, redirect and fetch-handshake signals of the program-counter unit.
interface pc_unit_if #(
    parameter int unsigned XLEN = 32
);
    import pc_pkg::*;

    // Handshake: pc is consumed on any cycle with pc_valid & fetch_ready & ~stall;
    // until then pc holds, unless a redirect replaces it (the offered pc then counts as consumed).
    logic            stall;
    logic            fetch_ready;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            call_push;
    logic            ret_pop;
    logic            trap;
    logic            halt;
    logic            resume;

    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_underflow;
    logic            halted;
    pc_state_e       state;

    modport master (
        output stall, fetch_ready, branch_taken, branch_target, call_push,
               ret_pop, trap, halt, resume,
        input  pc, pc_valid, epc, ras_empty, ras_full, ras_underflow, halted, state
    );

    modport slave (
        input  stall, fetch_ready, branch_taken, branch_target, call_push,
               ret_pop, trap, halt, resume,
        output pc, pc_valid, epc, ras_empty, ras_full, ras_underflow, halted, state
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rd_idx;
    logic [CW-1:0]    count;

    assign rd_idx = wp - PW'(1);
    assign top    = mem[rd_idx];
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));

    // Flush beats push beats pop; the pc unit never asks for push and pop together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp <= wp + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            wp    <= rd_idx;
            count <= count - CW'(1);
        end
    end

    // Entries are only read while count is non-zero, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run/halt control, prioritised redirects, call/return stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter int unsigned     RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

    pc_state_e       state;
    redirect_e       kind;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] ras_top;
    logic            pc_valid_q;
    logic            halted_q;
    logic            underflow_q;
    logic            fire;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_flush;
    logic            ras_empty;
    logic            ras_full;

    assign pc_seq = pc_q + STEP;
    assign fire   = pc_valid_q & bus.fetch_ready & ~bus.stall;

    // Decode the single action that wins this cycle; halt is left as NONE.
    always_comb begin
        kind      = NONE;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_flush = 1'b0;
        case (state)
            RUN: begin
                if (bus.trap) begin
                    kind      = TRAP;
                    ras_flush = 1'b1;
                end else if (bus.branch_taken) begin
                    kind     = BRANCH;
                    ras_push = bus.call_push;
                end else if (bus.ret_pop) begin
                    kind    = RET;
                    ras_pop = ~ras_empty;
                end else if (!bus.halt && fire) begin
                    kind = SEQ;
                end
            end
            HALT: begin
                if (bus.trap) begin
                    kind      = TRAP;
                    ras_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            pc_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            case (kind)
                TRAP: begin
                    pc_q  <= TRAP_VECTOR;
                    epc_q <= pc_q;
                end
                BRANCH: pc_q <= bus.branch_target & ALIGN_MASK;
                RET: begin
                    pc_q        <= ras_empty ? pc_seq : ras_top;
                    underflow_q <= ras_empty;
                end
                SEQ:     pc_q <= pc_seq;
                default: ;
            endcase

            case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (kind == NONE && bus.halt) begin
                        state      <= HALT;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.trap || bus.resume) begin
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.epc           = epc_q;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = underflow_q;
    assign bus.halted        = halted_q;
    assign bus.state         = state;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam int unsigned IB    = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pc_unit_if #(.XLEN(XLEN)) bus ();

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .INSTR_BYTES  (IB),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model and scoreboard
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_valid;
    bit          m_halted;
    bit          m_booting;
    bit          m_under;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_pc      = RV;
        m_epc     = '0;
        m_valid   = 1'b0;
        m_halted  = 1'b0;
        m_booting = 1'b1;
        m_under   = 1'b0;
        m_ras.delete();
        exp_q.delete();
    endtask

    task automatic model_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    endtask

    task automatic model_trap();
        m_epc = m_pc;
        m_pc  = TV;
        m_ras.delete();
    endtask

    // Next architectural state from the current one and the inputs driven this cycle.
    task automatic model_step();
        m_under = 1'b0;
        if (m_booting) begin
            m_booting = 1'b0;
            m_valid   = 1'b1;
        end else if (m_halted) begin
            if (bus.trap) begin
                model_trap();
                m_halted = 1'b0;
                m_valid  = 1'b1;
            end else if (bus.resume) begin
                m_halted = 1'b0;
                m_valid  = 1'b1;
            end
        end else if (bus.trap) begin
            model_trap();
        end else if (bus.branch_taken) begin
            if (bus.call_push) model_push(m_pc + IB);
            m_pc = bus.branch_target & ~(IB - 1);
        end else if (bus.ret_pop) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc    = m_pc + IB;
                m_under = 1'b1;
            end
        end else if (bus.halt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (bus.fetch_ready && !bus.stall) begin
            m_pc = m_pc + IB;
        end
        exp_q.push_back(m_pc);
    endtask

    task automatic check_all(input string pfx, input logic [31:0] exp_pc);
        check_eq({pfx, ".pc"},        bus.pc,            exp_pc);
        check_eq({pfx, ".pc_valid"},  32'(bus.pc_valid), 32'(m_valid));
        check_eq({pfx, ".epc"},       bus.epc,           m_epc);
        check_eq({pfx, ".ras_empty"}, 32'(bus.ras_empty), 32'(m_ras.size() == 0));
        check_eq({pfx, ".ras_full"},  32'(bus.ras_full),  32'(m_ras.size() == DEPTH));
        check_eq({pfx, ".underflow"}, 32'(bus.ras_underflow), 32'(m_under));
        check_eq({pfx, ".halted"},    32'(bus.halted),   32'(m_halted));
    endtask

    // ---------------- driver tasks
    task automatic drive(input bit br, input logic [31:0] tgt, input bit call, input bit ret,
                         input bit trp, input bit hlt, input bit res, input bit stl, input bit rdy);
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.call_push     = call;
        bus.ret_pop       = ret;
        bus.trap          = trp;
        bus.halt          = hlt;
        bus.resume        = res;
        bus.stall         = stl;
        bus.fetch_ready   = rdy;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step(input string pfx);
        model_step();
        @(posedge clk);
        #1;
        check_all(pfx, exp_q.pop_front());
    endtask

    task automatic branch_to(input logic [31:0] tgt, input bit call);
        drive(1'b1, tgt, call, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("branch");
    endtask

    // ---------------- stimulus
    initial begin
        idle();
        model_reset();
        #2 rst = 1'b1;
        #1 check_all("async_rst", m_pc);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", m_pc);
        rst = 1'b0;
        #1 check_all("boot", m_pc);

        // Boot then sequential fetch.
        step("boot_exit");
        check_eq("dir_boot_pc", bus.pc, 32'h0);
        check_eq("dir_boot_valid", 32'(bus.pc_valid), 32'd1);
        repeat (4) step("seq");
        check_eq("dir_seq_pc", bus.pc, 32'h10);

        // Stall two cycles, then one cycle without ready.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) step("stall");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("noready");
        check_eq("dir_hold_pc", bus.pc, 32'h10);
        idle();
        step("resume_seq");
        check_eq("dir_after_stall_pc", bus.pc, 32'h14);

        // Alignment and wrap.
        branch_to(32'h203, 1'b0);
        check_eq("dir_align_pc", bus.pc, 32'h200);
        branch_to(32'hFFFF_FFFC, 1'b0);
        idle();
        step("wrap");
        check_eq("dir_wrap_pc", bus.pc, 32'h0);

        // Five nested calls overflow a four-deep stack, then unwind.
        branch_to(32'h100, 1'b0);
        for (int i = 2; i <= 6; i++) branch_to(32'(i) << 8, 1'b1);
        check_eq("dir_ras_full", 32'(bus.ras_full), 32'd1);
        for (int i = 5; i >= 2; i--) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step("ret");
            check_eq("dir_ret_pc", bus.pc, (32'(i) << 8) + 32'h4);
        end
        step("ret_underflow");
        check_eq("dir_underflow_pc", bus.pc, 32'h208);
        check_eq("dir_underflow_pulse", 32'(bus.ras_underflow), 32'd1);
        idle();
        step("after_underflow");

        // Trap beats branch and return even while stalled.
        branch_to(32'h40, 1'b1);
        drive(1'b1, 32'h0000_0999, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("trap_prio");
        check_eq("dir_trap_pc", bus.pc, 32'h100);
        check_eq("dir_trap_epc", bus.epc, 32'h40);
        check_eq("dir_trap_empty", 32'(bus.ras_empty), 32'd1);

        // Halt, freeze, resume, then trap out of a second halt.
        branch_to(32'h80, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("halt");
        idle();
        repeat (4) step("halted");
        check_eq("dir_halt_pc", bus.pc, 32'h80);
        check_eq("dir_halt_flag", 32'(bus.halted), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("resume");
        check_eq("dir_resume_valid", 32'(bus.pc_valid), 32'd1);
        check_eq("dir_resume_pc", bus.pc, 32'h80);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("halt2");
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("halt_trap");
        check_eq("dir_halt_trap_pc", bus.pc, 32'h100);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 5) == 0,
                  $urandom(),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0);
            if (i == 400) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_all("mid_rst", m_pc);
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_all("mid_rst_hold", m_pc);
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage.
- Holds the PC, presents it to fetch over a valid/ready handshake, and advances it sequentially.
- Applies trap, branch and return redirects in fixed priority; supports halt/resume.
- Contains a circular return-address stack (RAS) for call/return prediction, and captures the exception PC on a trap.

Parameters:
XLEN, 32, PC/address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
INSTR_BYTES, 4, sequential increment; power of two, >=1
RAS_DEPTH, 4, return-address-stack entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC; does not block redirects
fetch_ready  in  1  fetch accepts the current pc this cycle
branch_taken  in  1  redirect to branch_target
branch_target  in  XLEN  branch destination
call_push  in  1  qualifies branch_taken as a call; push return address
ret_pop  in  1  return: redirect to RAS top
trap  in  1  redirect to TRAP_VECTOR
halt  in  1  enter HALT after the current cycle
resume  in  1  leave HALT
pc  out  XLEN  current program counter
pc_valid  out  1  pc is offered to fetch
epc  out  XLEN  PC captured at the last trap
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_underflow  out  1  one-cycle pulse: ret_pop with an empty RAS
halted  out  1  FSM is in HALT

Behaviour:
- Reset (async, active-high; outputs update immediately):
  - pc=RESET_VECTOR, epc=0, pc_valid=0, halted=0.
  - RAS count=0, so ras_empty=1 and ras_full=0; ras_underflow=0.
  - FSM enters BOOT.
  - Reset asserted mid-operation discards every pending event.
- FSM states: BOOT, RUN, HALT.
  - BOOT: pc_valid=0 for exactly one clk after rst deasserts, then RUN. Inputs are ignored in BOOT.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1, pc frozen.
    - resume -> RUN next cycle.
    - trap in HALT -> RUN with pc=TRAP_VECTOR.
    - All other inputs are ignored.
- "fire" = pc_valid & fetch_ready & ~stall.
- RUN next-pc priority, highest first (only one action applies per cycle):
  1. trap: pc<=TRAP_VECTOR; epc<=pc; RAS flushed (count=0). Takes effect regardless of stall or ready.
  2. branch_taken: pc<=branch_target with the low log2(INSTR_BYTES) bits forced to 0.
     - If call_push is also high, push pc+INSTR_BYTES.
     - If ret_pop is also high, it is ignored.
  3. ret_pop: if RAS not empty, pc<=top and pop. If empty, pc<=pc+INSTR_BYTES and pulse ras_underflow for one cycle.
  4. halt: pc unchanged; enter HALT next cycle.
  5. fire: pc<=pc+INSTR_BYTES.
  6. otherwise hold.
- Redirects are effective next cycle. A redirect in the same cycle as a fire overrides the increment; the offered pc counts as consumed.
- call_push without branch_taken is ignored.
- Arithmetic: all additions are modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0 with no flag.
- RAS: circular buffer with write pointer and count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop reads entry wp-1, decrements wp and count.
- Single-cycle latency; no combinational path from inputs to pc or pc_valid.

Decomposition:
- Shared package pc_pkg:
  - FSM state enum (BOOT, RUN, HALT).
  - Redirect-kind enum (NONE, TRAP, BRANCH, RET, SEQ).
  - Default vector constants.
- One sub-module, ras_stack:
  - Parameters: DEPTH, WIDTH.
  - Ports: push, pop, flush, push_data, top, empty, full; same clk/rst.
  - Owns the circular pointer/count logic and overwrite-on-full.

Test Plan:
- Reset and boot: hold rst 3 cycles, release -> pc=0, pc_valid=0 for 1 cycle, then pc_valid=1. With fetch_ready=1 every cycle, pc steps 0x0, 0x4, 0x8, 0xC.
- Stall and backpressure: at pc=0x10, raise stall for 2 cycles, then drop fetch_ready for 1 cycle -> pc stays 0x10 for 3 cycles, then 0x14.
- Branch alignment and wrap: branch_taken with target 0x203 -> pc=0x200. Branch to 0xFFFF_FFFC, then fire -> pc=0x0.
- Call/return nesting: 5 calls from pc 0x100, 0x200, 0x300, 0x400, 0x500 with RAS_DEPTH=4 -> ras_full=1. Then 4 returns -> pc 0x504, 0x404, 0x304, 0x204. A 5th return -> pc = pc+4 with ras_underflow pulsed for 1 cycle.
- Trap priority: trap, branch_taken and ret_pop all asserted at pc=0x40 with stall=1 -> pc=0x100, epc=0x40, ras_empty=1.
- Halt flow: halt at pc=0x80 -> halted=1, pc_valid=0, pc frozen through 4 cycles of fetch_ready=1. resume -> RUN, pc=0x80, pc_valid=1. A trap while halted -> pc=0x100.
